// File: rtl/accel_spi_reader_pkg.sv
// Shared constants and state types for the ADXL362 SPI reader.
// Covers the sensor opcodes, the register map subset and the FSM encodings.
package accel_spi_reader_pkg;

  localparam logic [7:0] ADXL_WR       = 8'h0A;
  localparam logic [7:0] ADXL_RD       = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_XDATA     = 8'h08;
  localparam logic [7:0] PWR_MEASURE   = 8'h02;

  typedef enum logic [2:0] {
    StPwrWait,
    StCfg,
    StIdle,
    StRead,
    StUpdate
  } reader_state_e;

  typedef enum logic [2:0] {
    ShIdle,
    ShSetup,
    ShLow,
    ShHigh,
    ShHold,
    ShGap
  } shifter_state_e;

  // Negation that clamps -128 to +127 instead of wrapping back to -128.
  function automatic logic [7:0] sat_neg(input logic [7:0] raw);
    return (raw == 8'h80) ? 8'h7F : ((~raw) + 8'd1);
  endfunction

endpackage

// File: rtl/accel_spi_reader_if.sv
// SPI pin bundle between the reader (master) and the accelerometer (slave).
interface accel_spi_reader_if;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_cs_n;
  logic spi_miso;

  modport master (output spi_sclk, output spi_mosi, output spi_cs_n, input spi_miso);
  modport slave  (input spi_sclk, input spi_mosi, input spi_cs_n, output spi_miso);
endinterface

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: owns CS/SCLK/MOSI timing for a multi-byte transfer.
// Next tx byte and last flag are sampled at each byte boundary; done marks each finished byte.
module spi_byte_shifter
  import accel_spi_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       last_byte,
  output logic [7:0] rx_byte,
  output logic       done,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  shifter_state_e  state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      tx_q;
  logic            last_q;
  logic            phase_end;

  assign phase_end = (cnt_q == CntW'(CLK_DIV - 1));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ShIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      last_q  <= 1'b0;
      rx_byte <= '0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state_q != ShIdle) cnt_q <= phase_end ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        ShIdle: begin
          if (start) begin
            cs_n    <= 1'b0;
            mosi    <= tx_byte[7];
            tx_q    <= {tx_byte[6:0], 1'b0};
            last_q  <= last_byte;
            bit_q   <= '0;
            state_q <= ShSetup;
          end
        end
        ShSetup: if (phase_end) state_q <= ShLow;
        ShLow: begin
          if (phase_end) begin
            sclk    <= 1'b1;
            rx_byte <= {rx_byte[6:0], miso};
            state_q <= ShHigh;
            // The final byte reports completion only once CS is released.
            if (bit_q == 3'd7 && !last_q) done <= 1'b1;
          end
        end
        ShHigh: begin
          if (phase_end) begin
            sclk  <= 1'b0;
            bit_q <= bit_q + 3'd1;
            if (bit_q != 3'd7) begin
              mosi    <= tx_q[7];
              tx_q    <= {tx_q[6:0], 1'b0};
              state_q <= ShLow;
            end else if (last_q) begin
              state_q <= ShHold;
            end else begin
              mosi    <= tx_byte[7];
              tx_q    <= {tx_byte[6:0], 1'b0};
              last_q  <= last_byte;
              state_q <= ShLow;
            end
          end
        end
        ShHold: begin
          if (phase_end) begin
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            done    <= 1'b1;
            state_q <= ShGap;
          end
        end
        ShGap: if (phase_end) state_q <= ShIdle;
        default: state_q <= ShIdle;
      endcase
    end
  end

endmodule

// File: rtl/accel_spi_reader.sv
// ADXL362 front end: one-time power-up configuration, then periodic X/Y burst reads.
// Sample timer runs across all post-config states so read starts are exactly SAMPLE_PERIOD apart.
module accel_spi_reader
  import accel_spi_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 50,
  parameter int unsigned SAMPLE_PERIOD = 1_000_000,
  parameter int unsigned INIT_WAIT     = 1_000_000,
  parameter bit          INVERT_X      = 1'b0,
  parameter bit          INVERT_Y      = 1'b0
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       i_enable,
  accel_spi_reader_if.master         spi,
  output logic [7:0]                 accel_x,
  output logic [7:0]                 accel_y,
  output logic                       o_sample_valid,
  output logic                       o_ready
);

  // Read start to shifter idle again: 66 CS-low half-periods, CS rise, gap, update.
  localparam int unsigned MinPeriod = 67 * CLK_DIV + 2;

  reader_state_e state_q;
  logic [31:0]   wait_q;
  logic [31:0]   timer_q;
  logic [1:0]    byte_idx_q;
  logic [7:0]    x_raw_q;

  logic          sh_start;
  logic          sh_done;
  logic [7:0]    sh_rx;
  logic [7:0]    tx_byte;
  logic          last_byte;
  logic          cfg_start;
  logic          read_start;

  assign cfg_start  = (state_q == StPwrWait) && (wait_q == 32'(INIT_WAIT - 1));
  assign read_start = (state_q == StIdle) && i_enable && (timer_q == 32'(SAMPLE_PERIOD - 1));
  assign sh_start   = cfg_start || read_start;

  always_comb begin
    tx_byte   = 8'h00;
    last_byte = 1'b0;
    if (state_q == StIdle || state_q == StRead) begin
      case (byte_idx_q)
        2'd0:    tx_byte = ADXL_RD;
        2'd1:    tx_byte = REG_XDATA;
        default: tx_byte = 8'h00;
      endcase
      last_byte = (byte_idx_q == 2'd3);
    end else begin
      case (byte_idx_q)
        2'd0:    tx_byte = ADXL_WR;
        2'd1:    tx_byte = REG_POWER_CTL;
        default: tx_byte = PWR_MEASURE;
      endcase
      last_byte = (byte_idx_q == 2'd2);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StPwrWait;
      wait_q         <= '0;
      timer_q        <= '0;
      byte_idx_q     <= '0;
      x_raw_q        <= '0;
      accel_x        <= '0;
      accel_y        <= '0;
      o_sample_valid <= 1'b0;
      o_ready        <= 1'b0;
    end else begin
      o_sample_valid <= 1'b0;
      if (o_ready && i_enable) begin
        timer_q <= (timer_q == 32'(SAMPLE_PERIOD - 1)) ? '0 : timer_q + 32'd1;
      end
      unique case (state_q)
        StPwrWait: begin
          if (cfg_start) state_q <= StCfg;
          else           wait_q  <= wait_q + 32'd1;
        end
        StCfg: begin
          if (sh_done) begin
            if (byte_idx_q == 2'd2) begin
              byte_idx_q <= '0;
              o_ready    <= 1'b1;
              state_q    <= StIdle;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        StIdle: if (read_start) state_q <= StRead;
        StRead: begin
          if (sh_done) begin
            if (byte_idx_q == 2'd2) x_raw_q <= sh_rx;
            if (byte_idx_q == 2'd3) begin
              byte_idx_q     <= '0;
              accel_x        <= INVERT_X ? sat_neg(x_raw_q) : x_raw_q;
              accel_y        <= INVERT_Y ? sat_neg(sh_rx) : sh_rx;
              o_sample_valid <= 1'b1;
              state_q        <= StUpdate;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        StUpdate: state_q <= StIdle;
        default:  state_q <= StPwrWait;
      endcase
    end
  end

  spi_byte_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .start    (sh_start),
    .tx_byte  (tx_byte),
    .last_byte(last_byte),
    .rx_byte  (sh_rx),
    .done     (sh_done),
    .miso     (spi.spi_miso),
    .sclk     (spi.spi_sclk),
    .mosi     (spi.spi_mosi),
    .cs_n     (spi.spi_cs_n)
  );

  clk_div_min: assert property (@(posedge CLK) disable iff (!rst_n) CLK_DIV >= 2);
  period_fits_read: assert property (@(posedge CLK) disable iff (!rst_n)
                                     SAMPLE_PERIOD > MinPeriod);

endmodule

// File: tb/tb_accel_spi_reader.sv
// Directed bench: a plain and an inverting reader share clock/reset, each with a sensor model.
module tb_accel_spi_reader;

  localparam int unsigned ClkDiv       = 2;
  localparam int unsigned InitWait     = 20;
  localparam int unsigned SamplePeriod = 400;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  always #5 clk = ~clk;

  accel_spi_reader_if spi0 ();
  accel_spi_reader_if spi1 ();

  logic [7:0] x0, y0, x1, y1;
  logic       v0, v1, r0, r1;

  accel_spi_reader #(
    .CLK_DIV(ClkDiv), .SAMPLE_PERIOD(SamplePeriod), .INIT_WAIT(InitWait),
    .INVERT_X(1'b0), .INVERT_Y(1'b0)
  ) dut (
    .CLK(clk), .rst_n(rst_n), .i_enable(en), .spi(spi0),
    .accel_x(x0), .accel_y(y0), .o_sample_valid(v0), .o_ready(r0)
  );

  accel_spi_reader #(
    .CLK_DIV(ClkDiv), .SAMPLE_PERIOD(SamplePeriod), .INIT_WAIT(InitWait),
    .INVERT_X(1'b1), .INVERT_Y(1'b1)
  ) dut_inv (
    .CLK(clk), .rst_n(rst_n), .i_enable(en), .spi(spi1),
    .accel_x(x1), .accel_y(y1), .o_sample_valid(v1), .o_ready(r1)
  );

  // Sensor replies {cmd, addr, X, Y}: MISO bit index follows the SCLK rising-edge count.
  logic [31:0] resp0 = 32'h0000_12F0;
  logic [31:0] resp1 = 32'h0000_8005;
  int unsigned rises0, rises1;
  logic [31:0] mosi_sr0, mosi_sr1;

  always @(posedge spi0.spi_sclk or negedge spi0.spi_cs_n) begin
    if (spi0.spi_sclk) begin
      rises0   <= rises0 + 1;
      mosi_sr0 <= {mosi_sr0[30:0], spi0.spi_mosi};
    end else begin
      rises0   <= 0;
      mosi_sr0 <= '0;
    end
  end

  always @(posedge spi1.spi_sclk or negedge spi1.spi_cs_n) begin
    if (spi1.spi_sclk) begin
      rises1   <= rises1 + 1;
      mosi_sr1 <= {mosi_sr1[30:0], spi1.spi_mosi};
    end else begin
      rises1   <= 0;
      mosi_sr1 <= '0;
    end
  end

  assign spi0.spi_miso = (rises0 < 32) ? resp0[5'(31 - rises0)] : 1'b0;
  assign spi1.spi_miso = (rises1 < 32) ? resp1[5'(31 - rises1)] : 1'b0;

  int cyc = 0;
  int pulses0 = 0;
  int falls0 = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (v0 === 1'b1) pulses0 <= pulses0 + 1;
  always @(negedge spi0.spi_cs_n) falls0 <= falls0 + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_cs(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = (spi0.spi_cs_n === level);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit ok;
  int t_rel, t_fall, t_ready, t_r0, t_r1, t_r2, p_save, f_save;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) step();
    check_eq("rst cs_n", {31'd0, spi0.spi_cs_n}, 32'd1);
    check_eq("rst sclk", {31'd0, spi0.spi_sclk}, 32'd0);
    check_eq("rst mosi", {31'd0, spi0.spi_mosi}, 32'd0);
    check_eq("rst outs", {16'd0, x0, y0}, 32'd0);
    check_eq("rst valid/ready", {30'd0, v0, r0}, 32'd0);
    check_eq("rst inv cs/outs", {23'd0, spi1.spi_cs_n, x1, y1}, 32'h0001_0000);

    // Enable is already high during power-up wait and config; it must have no effect.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    t_rel = cyc;
    wait_cs(1'b0, 100, ok);
    check_eq("cfg cs fall seen", {31'd0, ok}, 32'd1);
    check_eq("init wait cycles", cyc - t_rel, 32'd20);
    t_fall = cyc;
    wait_cs(1'b1, 300, ok);
    check_eq("cfg cs rise seen", {31'd0, ok}, 32'd1);
    check_eq("cfg cs low cycles", cyc - t_fall, 32'd100);
    check_eq("cfg mosi bit count", rises0, 32'd24);
    check_eq("cfg mosi bytes", mosi_sr0, 32'h000A_2D02);
    check_eq("ready before cs rise+1", {31'd0, r0}, 32'd0);
    step();
    check_eq("ready after cs rise", {30'd0, r0, r1}, 32'd3);
    t_ready = cyc;

    wait_cs(1'b0, 600, ok);
    check_eq("read1 cs fall seen", {31'd0, ok}, 32'd1);
    check_eq("ready to first read", cyc - t_ready, 32'd400);
    t_r0 = cyc;
    wait_cs(1'b1, 300, ok);
    check_eq("read1 cs rise seen", {31'd0, ok}, 32'd1);
    check_eq("read cs low cycles", cyc - t_r0, 32'd132);
    check_eq("valid at cs rise", {31'd0, v0}, 32'd0);
    check_eq("read mosi bytes", mosi_sr0, 32'h0B08_0000);
    step();
    check_eq("valid pulse", {30'd0, v0, v1}, 32'd3);
    check_eq("sample x/y", {16'd0, x0, y0}, 32'h0000_12F0);
    check_eq("inverted x/y", {16'd0, x1, y1}, 32'h0000_7FFB);
    step();
    check_eq("valid single cycle", {31'd0, v0}, 32'd0);

    wait_cs(1'b0, 600, ok);
    check_eq("read2 cs fall seen", {31'd0, ok}, 32'd1);
    check_eq("read period", cyc - t_r0, 32'd400);
    t_r1   = cyc;
    p_save = pulses0;
    repeat (20) step();
    en = 1'b0;
    f_save = falls0;
    repeat (300) step();
    check_eq("gated read completes", pulses0 - p_save, 32'd1);
    check_eq("no cs while disabled", falls0 - f_save, 32'd0);
    check_eq("cs idle while disabled", {31'd0, spi0.spi_cs_n}, 32'd1);
    check_eq("held sample", {16'd0, x0, y0}, 32'h0000_12F0);
    en = 1'b1;
    wait_cs(1'b0, 1000, ok);
    check_eq("read3 cs fall seen", {31'd0, ok}, 32'd1);
    check_eq("timer resumes held", cyc - t_r1, 32'd700);
    t_r2 = cyc;

    // Bit 5 of the command byte is in its SCLK-high phase after 24 cycles.
    repeat (24) step();
    check_eq("bit5 sclk/cs", {30'd0, spi0.spi_sclk, spi0.spi_cs_n}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async cs/sclk", {30'd0, spi0.spi_cs_n, spi0.spi_sclk}, 32'd2);
    check_eq("async outs", {16'd0, x0, y0}, 32'd0);
    check_eq("async inv outs/ready", {14'd0, x1, y1, r0, r1}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    t_rel = cyc;
    wait_cs(1'b0, 100, ok);
    check_eq("re-init cs fall seen", {31'd0, ok}, 32'd1);
    check_eq("re-init wait cycles", cyc - t_rel, 32'd20);
    wait_cs(1'b1, 300, ok);
    check_eq("re-init cs rise seen", {31'd0, ok}, 32'd1);
    check_eq("re-init mosi bytes", mosi_sr0, 32'h000A_2D02);
    step();
    check_eq("re-init ready", {31'd0, r0}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/accel_spi_reader.md
# accel_spi_reader

Configures the board's ADXL362 accelerometer over SPI and periodically reads its 8-bit X/Y acceleration registers. It is the producer of the `accel_x`/`accel_y` bytes consumed by the ball-motion logic, so it sits between the board's SPI pins and the physics block. It performs a one-time power-up configuration, then issues a burst read every `SAMPLE_PERIOD` cycles while enabled, presenting held, optionally sign-inverted samples with a one-cycle valid strobe.

## Interface
- `CLK_DIV`, 50: CLK cycles per SCLK half-period (1 MHz SCLK at 100 MHz). Must be ≥2.
- `SAMPLE_PERIOD`, 1_000_000: CLK cycles between read-transaction starts (100 Hz).
- `INIT_WAIT`, 1_000_000: CLK cycles after reset before the configuration write.
- `INVERT_X`, 0: negate X sample before output.
- `INVERT_Y`, 0: negate Y sample before output.

Ports:
- `CLK` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_enable` in 1: permits periodic reads (tied to game-playing status).
- `spi_miso` in 1: sensor data out.
- `spi_sclk` out 1: SPI clock, mode 0.
- `spi_mosi` out 1: SPI data to sensor.
- `spi_cs_n` out 1: chip select, active low.
- `accel_x` out 8: latest X sample, two's complement.
- `accel_y` out 8: latest Y sample, two's complement.
- `o_sample_valid` out 1: one-cycle pulse when `accel_x`/`accel_y` update.
- `o_ready` out 1: high once configuration is complete; stays high until reset.

## Operation
- Reset values: `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `accel_x`=`accel_y`=0, `o_sample_valid`=0, `o_ready`=0. State is PWR_WAIT.
- PWR_WAIT: count `INIT_WAIT` cycles, then go to CFG.
- CFG: 3-byte write `0x0A, 0x2D, 0x02` (write command, POWER_CTL, measurement mode). When done, set `o_ready`=1 and go to IDLE.
- IDLE: the sample timer runs only while `i_enable`=1. It holds its count while `i_enable`=0. When it reaches `SAMPLE_PERIOD-1`, it clears and the block goes to READ.
- READ: 4-byte transfer `0x0B, 0x08, 0x00, 0x00` (read command, XDATA address, two dummy bytes). MISO byte 3 is X; byte 4 is Y.
- UPDATE: takes one cycle. It registers both outputs and pulses `o_sample_valid`, then returns to IDLE.
- Inversion: the output is −raw. A raw value of 0x80 saturates to 0x7F, so −128 never wraps.
- If `i_enable` falls mid-READ, the transfer completes and the update still occurs. Outputs then hold their values indefinitely.
- If `i_enable` is asserted during PWR_WAIT or CFG, it has no effect until `o_ready`=1.
- If reset asserts mid-transfer, `spi_cs_n` goes high and `spi_sclk` goes low immediately (asynchronously). The full init sequence then restarts.

## Timing
- SPI mode 0: SCLK idles low. MOSI is MSB-first and changes only while SCLK is low. MISO is registered on the CLK edge where SCLK rises.
- Transfer sequence:
  - `spi_cs_n` falls, followed by `CLK_DIV` cycles of setup.
  - Each bit takes `CLK_DIV` cycles with SCLK low (MOSI valid from the start of this phase), then `CLK_DIV` cycles with SCLK high.
  - After the last bit, SCLK is low for a `CLK_DIV`-cycle hold, then `spi_cs_n` rises.
- `spi_cs_n` stays high for at least `CLK_DIV` cycles between transfers.
- A READ lasts 2·`CLK_DIV` + 64·`CLK_DIV` cycles with CS low.
- `o_sample_valid` asserts exactly one cycle after `spi_cs_n` rises at the end of READ. Outputs change in that same cycle.
- The sample period is measured between READ starts. `SAMPLE_PERIOD` must exceed the READ length; this is a checked assertion.

## Structure
- A shared package holds the opcode constants (`ADXL_WR`=0x0A, `ADXL_RD`=0x0B), register addresses (`REG_POWER_CTL`=0x2D, `REG_XDATA`=0x08), `PWR_MEASURE`=0x02, and the state enum.
- One sub-module, `spi_byte_shifter`, handles the bit-level exchange:
  - Interface: start, tx byte, last-byte flag, rx byte, and a done pulse.
  - It owns SCLK/MOSI/CS timing.
  - The top level is the FSM, timers, and output registers.

## Test plan
- **Reset and init:** release `rst_n` with `INIT_WAIT`=20 and `CLK_DIV`=2. Required response: CS stays high for 20 cycles, then MOSI carries 0x0A, 0x2D, 0x02 and `o_ready` rises after CS rises.
- **Sample read:** sensor model returns X=0x12, Y=0xF0 with `i_enable`=1. Required response: `accel_x`=0x12, `accel_y`=0xF0, and one `o_sample_valid` pulse per READ.
- **Inversion and saturation:** set `INVERT_X`=1 and `INVERT_Y`=1 with X=0x80, Y=0x05. Required response: outputs are 0x7F and 0xFB.
- **Enable gating:** drop `i_enable` mid-READ. Required response: the transfer finishes, one update occurs, and no further CS activity follows until `i_enable` returns. Timer resumes from its held count.
- **Async reset mid-transfer:** assert `rst_n`=0 during bit 5 of a READ. Required response: CS=1, SCLK=0, and outputs=0 within the same cycle, then the full init sequence repeats.
- **Periodicity:** with `SAMPLE_PERIOD`=400, measure CS falling edges. Required response: they are exactly 400 cycles apart.
